// File: rtl/rng_sequencer.sv
// Sequences the ring-oscillator entropy core, whitens captures (raw ^ previous raw), runs a repetition-count health test and queues words.
// Latency: first out_valid arrives WARMUP_CYCLES + 2*SAMPLE_INTERVAL + 2 cycles after run rises in IDLE (run cycle counted as cycle 1).
// Backpressure: out_valid/out_ready. A full FIFO stalls the sample counter at the capture point until a slot frees, including a same-cycle pop.
module rng_sequencer #(
    parameter int NUMBITS         = 32,
    parameter int WARMUP_CYCLES   = 64,
    parameter int SAMPLE_INTERVAL = 4,
    parameter int REP_LIMIT       = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          clear_fault,
    output logic                          rng_enable,
    input  logic [NUMBITS-1:0]            rng_data,
    output logic [NUMBITS-1:0]            out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          health_fail,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int SW = $clog2(SAMPLE_INTERVAL);
    localparam int RW = $clog2(REP_LIMIT);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_INTERVAL - 1);
    localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SAMPLE,
        ST_FAULT
    } state_t;

    state_t               state, state_nxt;
    logic [WW-1:0]        warm_cnt, warm_cnt_nxt;
    logic [SW-1:0]        samp_cnt, samp_cnt_nxt;
    logic [NUMBITS-1:0]   prev, prev_nxt;
    logic                 prev_valid, prev_valid_nxt;
    logic [RW-1:0]        rep_count, rep_count_nxt;

    logic [NUMBITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop, full, at_capture, capture, trip;
    logic [RW-1:0]        rep_inc;

    assign out_valid  = (fifo_count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign pop        = out_valid & out_ready;
    assign full       = (fifo_count == FIFO_FULL);
    assign at_capture = (state == ST_SAMPLE) && (samp_cnt == SAMP_LAST);
    // A pop in the same cycle frees the slot the capture needs.
    assign capture    = at_capture && (!full || pop);
    // rep_count tracks identical comparisons; a differing word restarts it at 1.
    assign rep_inc    = (rng_data == prev) ? rep_count + RW'(1) : RW'(1);
    assign trip       = capture && prev_valid && (rep_inc == REP_TRIP);

    // Next-state, counter and capture decisions; fault entry outranks run=0, which outranks capture.
    always_comb begin
        state_nxt      = state;
        warm_cnt_nxt   = warm_cnt;
        samp_cnt_nxt   = samp_cnt;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        rep_count_nxt  = rep_count;
        push           = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt    = ST_WARMUP;
                    warm_cnt_nxt = '0;
                end
            end
            ST_WARMUP: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (warm_cnt == WARM_LAST) begin
                    state_nxt      = ST_SAMPLE;
                    samp_cnt_nxt   = '0;
                    prev_valid_nxt = 1'b0;
                end else begin
                    warm_cnt_nxt = warm_cnt + WW'(1);
                end
            end
            ST_SAMPLE: begin
                if (trip) begin
                    state_nxt     = ST_FAULT;
                    rep_count_nxt = rep_inc;
                end else if (!run) begin
                    state_nxt      = ST_IDLE;
                    prev_valid_nxt = 1'b0;
                    rep_count_nxt  = '0;
                end else if (capture) begin
                    samp_cnt_nxt   = '0;
                    prev_nxt       = rng_data;
                    prev_valid_nxt = 1'b1;
                    if (prev_valid) begin
                        push          = 1'b1;
                        rep_count_nxt = rep_inc;
                    end
                end else if (!at_capture) begin
                    samp_cnt_nxt = samp_cnt + SW'(1);
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_nxt      = ST_IDLE;
                    rep_count_nxt  = '0;
                    prev_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            warm_cnt    <= '0;
            samp_cnt    <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            rep_count   <= '0;
            rng_enable  <= 1'b0;
            busy        <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            state       <= state_nxt;
            warm_cnt    <= warm_cnt_nxt;
            samp_cnt    <= samp_cnt_nxt;
            prev        <= prev_nxt;
            prev_valid  <= prev_valid_nxt;
            rep_count   <= rep_count_nxt;
            rng_enable  <= (state_nxt == ST_WARMUP) || (state_nxt == ST_SAMPLE);
            busy        <= (state_nxt == ST_WARMUP) || (state_nxt == ST_SAMPLE);
            health_fail <= (state_nxt == ST_FAULT);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
        end
    end

    // FIFO storage; stale contents are hidden by gating out_data with out_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rng_data ^ prev;
    end

endmodule
